// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Owner encodings, FSM state type and wait-count range.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;

  // Down-counter load value; out-of-range wait counts are clamped into 1..15.
  function automatic logic [3:0] wait_load(input int unsigned w);
    int unsigned c;
    c = (w < WAIT_MIN) ? WAIT_MIN : ((w > WAIT_MAX) ? WAIT_MAX : w);
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester (fetch / data) arbiter for a single asynchronous SRAM port.
// Fixed-length strobed access, one turnaround cycle, one-cycle ack; all outputs registered.
module sram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [31:0]       sram_rdata
);

  localparam logic [3:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              grant_mem;

  logic              ce_n_d, oe_n_d, we_n_d, wdata_oe_d, if_ack_d, mem_ack_d;
  logic [3:0]        be_n_d;

  // Byte-offset and above-window address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWN_IF;
      last_grant_q  <= OWN_IF;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      be_q          <= 4'hF;
      rdata_q       <= '0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= 4'hF;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_wdata_oe <= 1'b0;
      if_ack        <= 1'b0;
      mem_ack       <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      be_q          <= be_d;
      rdata_q       <= rdata_d;
      sram_ce_n     <= ce_n_d;
      sram_oe_n     <= oe_n_d;
      sram_we_n     <= we_n_d;
      sram_be_n     <= be_n_d;
      sram_addr     <= addr_d;
      sram_wdata    <= wdata_d;
      sram_wdata_oe <= wdata_oe_d;
      if_ack        <= if_ack_d;
      mem_ack       <= mem_ack_d;
    end
  end

  // Next-state: grant selection, request latching, wait counting.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = sram_addr;
    wdata_d      = sram_wdata;
    grant_mem    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (if_req || mem_req) begin
          // Tie goes to whoever was not granted last.
          grant_mem = mem_req && (!if_req || (last_grant_q == OWN_IF));
          state_d   = ARB_ACCESS;
          cnt_d     = CNT_LOAD;
          if (grant_mem) begin
            owner_d = OWN_MEM;
            we_d    = mem_we;
            be_d    = mem_be;
            addr_d  = mem_addr[ADDR_W+1:2];
            wdata_d = mem_wdata;
          end else begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            be_d    = 4'hF;
            addr_d  = if_addr[ADDR_W+1:2];
          end
          last_grant_d = owner_d;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == 4'd0) state_d = ARB_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    ce_n_d     = (state_d != ARB_ACCESS);
    oe_n_d     = !((state_d == ARB_ACCESS) && !we_d);
    we_n_d     = !((state_d == ARB_ACCESS) && we_d);
    wdata_oe_d = (state_d == ARB_ACCESS) && we_d;
    be_n_d     = (state_d == ARB_ACCESS) ? ~be_d : 4'hF;
    if_ack_d   = (state_d == ARB_DONE) && (owner_d == OWN_IF);
    mem_ack_d  = (state_d == ARB_DONE) && (owner_d == OWN_MEM);
    rdata_d    = rdata_q;
    if ((state_q == ARB_ACCESS) && (cnt_q == 4'd0) && !we_q) rdata_d = sram_rdata;
  end

  assign if_rdata  = rdata_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle tables plus multi-cycle sequences
// on three instances (W=2, W=1, W=15) sharing one stimulus set.
module tb_sram_arbiter;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] sram_rdata;
  } ins_t;

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [3:0]  be_n;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic        wdata_oe;
    logic        if_ack;
    logic        mem_ack;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
  } outs_t;

  typedef struct packed {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] sram_rdata = '0;

  logic        d2_if_ack, d2_mem_ack, d2_ce_n, d2_oe_n, d2_we_n, d2_woe;
  logic [31:0] d2_if_rdata, d2_mem_rdata, d2_wdata;
  logic [3:0]  d2_be_n;
  logic [19:0] d2_addr;
  logic        d1_if_ack, d1_mem_ack, d1_ce_n, d1_oe_n, d1_we_n, d1_woe;
  logic [31:0] d1_if_rdata, d1_mem_rdata, d1_wdata;
  logic [3:0]  d1_be_n;
  logic [19:0] d1_addr;
  logic        d15_if_ack, d15_mem_ack, d15_ce_n, d15_oe_n, d15_we_n, d15_woe;
  logic [31:0] d15_if_rdata, d15_mem_rdata, d15_wdata;
  logic [3:0]  d15_be_n;
  logic [19:0] d15_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2)) u_d2 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(d2_if_ack),
    .if_rdata(d2_if_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(d2_mem_ack),
    .mem_rdata(d2_mem_rdata), .sram_ce_n(d2_ce_n), .sram_oe_n(d2_oe_n),
    .sram_we_n(d2_we_n), .sram_be_n(d2_be_n), .sram_addr(d2_addr),
    .sram_wdata(d2_wdata), .sram_wdata_oe(d2_woe), .sram_rdata(sram_rdata)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) u_d1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(d1_if_ack),
    .if_rdata(d1_if_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(d1_mem_ack),
    .mem_rdata(d1_mem_rdata), .sram_ce_n(d1_ce_n), .sram_oe_n(d1_oe_n),
    .sram_we_n(d1_we_n), .sram_be_n(d1_be_n), .sram_addr(d1_addr),
    .sram_wdata(d1_wdata), .sram_wdata_oe(d1_woe), .sram_rdata(sram_rdata)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(15)) u_d15 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(d15_if_ack),
    .if_rdata(d15_if_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(d15_mem_ack),
    .mem_rdata(d15_mem_rdata), .sram_ce_n(d15_ce_n), .sram_oe_n(d15_oe_n),
    .sram_we_n(d15_we_n), .sram_be_n(d15_be_n), .sram_addr(d15_addr),
    .sram_wdata(d15_wdata), .sram_wdata_oe(d15_woe), .sram_rdata(sram_rdata)
  );

  function automatic ins_t mk_in(input logic ir, input logic [31:0] ia, input logic mr,
                                 input logic mw, input logic [3:0] mb, input logic [31:0] ma,
                                 input logic [31:0] md, input logic [31:0] sr);
    ins_t r;
    r = '{if_req: ir, if_addr: ia, mem_req: mr, mem_we: mw, mem_be: mb, mem_addr: ma,
          mem_wdata: md, sram_rdata: sr};
    return r;
  endfunction

  function automatic outs_t mk_out(input logic ce, input logic oe, input logic we,
                                   input logic [3:0] be, input logic [19:0] a,
                                   input logic [31:0] wd, input logic woe, input logic ia,
                                   input logic ma, input logic [31:0] rd);
    outs_t r;
    r = '{ce_n: ce, oe_n: oe, we_n: we, be_n: be, addr: a, wdata: wd, wdata_oe: woe,
          if_ack: ia, mem_ack: ma, if_rdata: rd, mem_rdata: rd};
    return r;
  endfunction

  function automatic outs_t get_d2();
    return '{ce_n: d2_ce_n, oe_n: d2_oe_n, we_n: d2_we_n, be_n: d2_be_n, addr: d2_addr,
             wdata: d2_wdata, wdata_oe: d2_woe, if_ack: d2_if_ack, mem_ack: d2_mem_ack,
             if_rdata: d2_if_rdata, mem_rdata: d2_mem_rdata};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input ins_t v);
    if_req     = v.if_req;
    if_addr    = v.if_addr;
    mem_req    = v.mem_req;
    mem_we     = v.mem_we;
    mem_be     = v.mem_be;
    mem_addr   = v.mem_addr;
    mem_wdata  = v.mem_wdata;
    sram_rdata = v.sram_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    apply('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    ins_t  in_if, in_wr, in_idle;
    outs_t acc_rd, acc_wr;
    int    k;
    bit    seen;

    in_if   = mk_in(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    in_wr   = mk_in(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'h12345678, 32'hCAFEF00D);
    in_idle = mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    acc_rd  = mk_out(0, 0, 1, 4'h0, 20'h4, 32'h0, 0, 0, 0, 32'h0);
    acc_wr  = mk_out(0, 1, 0, 4'hC, 20'h40, 32'h12345678, 1, 0, 0, 32'hDEADBEEF);
    vecs[0] = '{in: in_if, exp: acc_rd};
    vecs[1] = '{in: in_if, exp: acc_rd};
    vecs[2] = '{in: in_if, exp: mk_out(1, 1, 1, 4'hF, 20'h4, 32'h0, 0, 1, 0, 32'hDEADBEEF)};
    vecs[3] = '{in: in_idle, exp: mk_out(1, 1, 1, 4'hF, 20'h4, 32'h0, 0, 0, 0, 32'hDEADBEEF)};
    vecs[4] = '{in: in_wr, exp: acc_wr};
    vecs[5] = '{in: in_wr, exp: acc_wr};
    vecs[6] = '{in: in_wr,
                exp: mk_out(1, 1, 1, 4'hF, 20'h40, 32'h12345678, 0, 0, 1, 32'hDEADBEEF)};
    vecs[7] = '{in: in_idle,
                exp: mk_out(1, 1, 1, 4'hF, 20'h40, 32'h12345678, 0, 0, 0, 32'hDEADBEEF)};

    // Reset values on every instance.
    do_reset();
    #1;
    check("reset_d2", 128'(get_d2()), 128'(mk_out(1, 1, 1, 4'hF, 20'h0, 32'h0, 0, 0, 0, 32'h0)));
    check("reset_d1", {d1_ce_n, d1_oe_n, d1_we_n, d1_be_n, d1_addr, d1_wdata, d1_woe,
                       d1_if_ack, d1_mem_ack, d1_if_rdata},
          {3'b111, 4'hF, 20'h0, 32'h0, 3'b000, 32'h0});
    check("reset_d15", {d15_ce_n, d15_oe_n, d15_we_n, d15_be_n, d15_addr, d15_woe,
                        d15_if_ack, d15_mem_ack, d15_mem_rdata},
          {3'b111, 4'hF, 20'h0, 3'b000, 32'h0});

    // IF read then MEM write, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].in);
      step();
      check($sformatf("vec%0d", i), 128'(get_d2()), 128'(vecs[i].exp));
    end

    // Both requests held: MEM, IF, MEM, IF with acks four cycles apart.
    do_reset();
    apply(mk_in(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h11112222));
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("alt_c%0d", c), {d2_if_ack, d2_mem_ack},
            {(c == 7 || c == 15), (c == 3 || c == 11)});
    end

    // Held if_req on the W=1 instance: ack every third cycle, ce_n high outside ACCESS.
    do_reset();
    apply(mk_in(1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0));
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("w1_c%0d", c), {d1_if_ack, d1_ce_n, d1_mem_ack},
            {(c % 3 == 2), (c % 3 != 1), 1'b0});
    end

    // Reset asserted during the first ACCESS cycle of a write.
    do_reset();
    apply(mk_in(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h200, 32'hA5A5A5A5, 32'h0));
    step();
    check("midrst_pre", {d2_we_n, d2_ce_n, d2_woe}, {1'b0, 1'b0, 1'b1});
    #2 rst = 1'b0;
    #1;
    check("midrst_async", {d2_ce_n, d2_we_n, d2_woe, d2_be_n, d2_mem_ack},
          {1'b1, 1'b1, 1'b0, 4'hF, 1'b0});
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(mk_in(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h55AA55AA));
    k = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && k == 0; c++) begin
      step();
      if (d2_mem_ack) seen = 1'b1;
      if (d2_if_ack) k = c;
    end
    if_req = 1'b0;
    check("midrst_if_lat", 32'(k), 32'd3);
    check("midrst_rdata", d2_if_rdata, 32'h55AA55AA);
    check("midrst_no_mem_ack", 1'(seen), 1'b0);

    // W=15: ack exactly 16 cycles after the request.
    do_reset();
    apply(mk_in(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0F0F1234));
    k = 0;
    for (int c = 1; c <= 40 && k == 0; c++) begin
      step();
      if (d15_if_ack) k = c;
    end
    if_req = 1'b0;
    check("w15_latency", 32'(k), 32'd16);
    check("w15_rdata", d15_if_rdata, 32'h0F0F1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
